// File: rtl/game_state_if.sv
// Frame-level handshake bundle between the game-flow controller and
// the VGA timing, input and pixel stages.
interface game_state_if;
   logic       frame_tick;
   logic       btn_start;
   logic       ball_lost;
   logic       bricks_clear;
   logic       init;
   logic       serve;
   logic       play;
   logic       dead;
   logic       win;
   logic [1:0] lives;

   modport master (
      output frame_tick, btn_start, ball_lost, bricks_clear,
      input  init, serve, play, dead, win, lives
   );

   modport slave (
      input  frame_tick, btn_start, ball_lost, bricks_clear,
      output init, serve, play, dead, win, lives
   );
endinterface

// File: rtl/game_state.sv
// Arkanoid game-flow controller: INIT/SERVE/PLAY/DEAD/WIN sequencing and
// life counting, with all mode changes applied only on the frame tick.
module game_state #(
   parameter int LIVES        = 3,
   parameter int SERVE_FRAMES = 60,
   parameter int HOLD_FRAMES  = 180
) (
   input  logic         clk,
   input  logic         rst,
   game_state_if.slave  bus
);
   typedef enum logic [2:0] {
      S_INIT,
      S_SERVE,
      S_PLAY,
      S_DEAD,
      S_WIN
   } state_t;

   localparam logic [1:0] LIVES_INIT = 2'(LIVES);
   localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);

   state_t     r_state;
   logic [1:0] r_lives;
   logic [7:0] r_fcnt;
   logic       r_btn_q;
   logic       r_start_l;
   logic       r_lost_l;
   logic       r_clear_l;
   logic       r_init;
   logic       r_serve;
   logic       r_play;
   logic       r_dead;
   logic       r_win;

   state_t     w_next;
   logic [1:0] w_lives_next;
   logic       w_press;
   logic       w_start;
   logic       w_lost;
   logic       w_clear;

   // Events landing in the tick cycle itself still count for that tick.
   assign w_press = bus.btn_start & ~r_btn_q;
   assign w_start = r_start_l | w_press;
   assign w_lost  = r_lost_l | bus.ball_lost;
   assign w_clear = r_clear_l | bus.bricks_clear;

   always_comb begin
      w_next       = r_state;
      w_lives_next = r_lives;
      unique case (r_state)
         S_INIT: begin
            if (w_start) begin
               w_next       = S_SERVE;
               w_lives_next = LIVES_INIT;
            end
         end
         S_SERVE: begin
            if (w_start || r_fcnt == SERVE_LAST) begin
               w_next = S_PLAY;
            end
         end
         S_PLAY: begin
            if (w_clear) begin
               w_next = S_WIN;
            end else if (w_lost) begin
               if (r_lives <= 2'd1) begin
                  w_next       = S_DEAD;
                  w_lives_next = 2'd0;
               end else begin
                  w_next       = S_SERVE;
                  w_lives_next = r_lives - 2'd1;
               end
            end
         end
         S_DEAD, S_WIN: begin
            if (r_fcnt == HOLD_LAST) begin
               w_next = S_INIT;
            end
         end
         default: begin
            w_next = S_INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_INIT;
         r_lives   <= LIVES_INIT;
         r_fcnt    <= 8'd0;
         r_btn_q   <= 1'b1;
         r_start_l <= 1'b0;
         r_lost_l  <= 1'b0;
         r_clear_l <= 1'b0;
         r_init    <= 1'b1;
         r_serve   <= 1'b0;
         r_play    <= 1'b0;
         r_dead    <= 1'b0;
         r_win     <= 1'b0;
      end else begin
         r_btn_q <= bus.btn_start;
         if (bus.frame_tick) begin
            // Unconsumed events are dropped at the frame boundary.
            r_start_l <= 1'b0;
            r_lost_l  <= 1'b0;
            r_clear_l <= 1'b0;
            r_state   <= w_next;
            r_lives   <= w_lives_next;
            r_fcnt    <= (w_next != r_state) ? 8'd0 : r_fcnt + 8'd1;
            r_init    <= (w_next == S_INIT);
            r_serve   <= (w_next == S_SERVE);
            r_play    <= (w_next == S_PLAY);
            r_dead    <= (w_next == S_DEAD);
            r_win     <= (w_next == S_WIN);
         end else begin
            r_start_l <= w_start;
            r_lost_l  <= w_lost;
            r_clear_l <= w_clear;
         end
      end
   end

   assign bus.init  = r_init;
   assign bus.serve = r_serve;
   assign bus.play  = r_play;
   assign bus.dead  = r_dead;
   assign bus.win   = r_win;
   assign bus.lives = r_lives;
endmodule

// File: tb/tb_game_state.sv
// Scoreboard bench for game_state: stimulus queues expected modes per tick,
// a monitor pops them and also checks outputs hold between ticks.
module tb_game_state;
   localparam logic [4:0] M_INIT  = 5'b10000;
   localparam logic [4:0] M_SERVE = 5'b01000;
   localparam logic [4:0] M_PLAY  = 5'b00100;
   localparam logic [4:0] M_DEAD  = 5'b00010;
   localparam logic [4:0] M_WIN   = 5'b00001;

   typedef struct {
      logic [4:0] mode;
      logic [1:0] lives;
      string      name;
   } exp_t;

   logic clk;
   logic rst;
   game_state_if bus ();

   game_state #(
      .LIVES        (3),
      .SERVE_FRAMES (4),
      .HOLD_FRAMES  (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   exp_t q[$];
   int   n_total = 0;
   int   n_pass  = 0;
   logic strobe_d = 1'b0;
   logic have_prev = 1'b0;
   logic [6:0] prev;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) strobe_d <= bus.frame_tick | rst;

   always @(negedge clk) begin : monitor
      exp_t       e;
      logic [6:0] cur;
      cur = {bus.init, bus.serve, bus.play, bus.dead, bus.win, bus.lives};
      if (strobe_d) begin
         n_total++;
         if (q.size() == 0) begin
            $display("FAIL unexpected_tick: got %b, no expectation queued", cur);
         end else begin
            e = q.pop_front();
            if (cur === {e.mode, e.lives}) n_pass++;
            else $display("FAIL %s: got mode=%b lives=%0d, want mode=%b lives=%0d",
                          e.name, cur[6:2], cur[1:0], e.mode, e.lives);
         end
      end else if (have_prev) begin
         n_total++;
         if (cur === prev) n_pass++;
         else $display("FAIL stable_between_ticks t=%0t: got %b, want %b",
                       $time, cur, prev);
      end
      prev      = cur;
      have_prev = 1'b1;
   end

   task automatic push(input logic [4:0] m, input logic [1:0] l,
                       input string n);
      exp_t e;
      e.mode  = m;
      e.lives = l;
      e.name  = n;
      q.push_back(e);
   endtask

   task automatic cycle(input logic ft, input logic bl, input logic bc);
      bus.frame_tick   = ft;
      bus.ball_lost    = bl;
      bus.bricks_clear = bc;
      @(posedge clk);
      #1;
      bus.frame_tick   = 1'b0;
      bus.ball_lost    = 1'b0;
      bus.bricks_clear = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick(input logic [4:0] m, input logic [1:0] l,
                       input string n, input logic bl = 1'b0,
                       input logic bc = 1'b0);
      push(m, l, n);
      cycle(1'b1, bl, bc);
   endtask

   task automatic press();
      bus.btn_start = 1'b1;
      idle(1);
      bus.btn_start = 1'b0;
      idle(2);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bus.frame_tick   = 1'b0;
      bus.btn_start    = 1'b0;
      bus.ball_lost    = 1'b0;
      bus.bricks_clear = 1'b0;
      rst = 1'b1;
      push(M_INIT, 2'd3, "reset_0");
      push(M_INIT, 2'd3, "reset_1");
      idle(2);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         idle(3);
         tick(M_INIT, 2'd3, "idle_init");
      end

      press();
      idle(5);
      tick(M_SERVE, 2'd3, "start_to_serve");
      for (int i = 0; i < 3; i++) begin
         idle(2);
         tick(M_SERVE, 2'd3, "serve_hold");
      end
      idle(2);
      tick(M_PLAY, 2'd3, "auto_launch");

      idle(3);
      tick(M_SERVE, 2'd2, "tick_aligned_loss", 1'b1);
      press();
      tick(M_PLAY, 2'd2, "press_launch");
      idle(3);
      tick(M_SERVE, 2'd1, "loss_to_1", 1'b1);
      for (int i = 0; i < 3; i++) tick(M_SERVE, 2'd1, "serve_hold_1");
      tick(M_PLAY, 2'd1, "auto_launch_1");
      tick(M_DEAD, 2'd0, "last_life_dead", 1'b1);
      press();
      tick(M_DEAD, 2'd0, "dead_ignores_start");
      tick(M_DEAD, 2'd0, "dead_hold");
      tick(M_INIT, 2'd0, "dead_to_init");

      press();
      tick(M_SERVE, 2'd3, "restart_lives_reload");
      press();
      tick(M_PLAY, 2'd3, "launch_again");
      idle(2);
      cycle(1'b0, 1'b1, 1'b0);
      idle(3);
      cycle(1'b0, 1'b0, 1'b1);
      idle(2);
      tick(M_WIN, 2'd3, "clear_beats_loss");
      tick(M_WIN, 2'd3, "win_hold_0");
      press();
      tick(M_WIN, 2'd3, "win_hold_1");
      tick(M_INIT, 2'd3, "win_to_init");

      press();
      tick(M_SERVE, 2'd3, "serve_again");
      press();
      tick(M_PLAY, 2'd3, "play_again");
      idle(5);
      cycle(1'b0, 1'b1, 1'b0);
      idle(40);
      cycle(1'b0, 1'b1, 1'b0);
      idle(58);
      tick(M_SERVE, 2'd2, "double_loss_one_life");

      press();
      tick(M_PLAY, 2'd2, "play_2");
      tick(M_SERVE, 2'd1, "loss_2_to_1", 1'b1);
      press();
      tick(M_PLAY, 2'd1, "play_1");
      tick(M_DEAD, 2'd0, "dead_again", 1'b1);
      idle(2);
      bus.btn_start = 1'b1;
      idle(2);
      rst = 1'b1;
      push(M_INIT, 2'd3, "reset_beats_tick");
      cycle(1'b1, 1'b1, 1'b0);
      rst = 1'b0;
      idle(2);
      tick(M_INIT, 2'd3, "held_btn_no_start_0");
      idle(2);
      tick(M_INIT, 2'd3, "held_btn_no_start_1");
      bus.btn_start = 1'b0;
      idle(2);
      press();
      tick(M_SERVE, 2'd3, "release_press_serve");
      idle(3);

      n_total++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d left, want 0", q.size());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
